// File: rtl/vector_inst_dispatcher.sv
// vector_inst_dispatcher
// Scalar-side issue port of the vector extension. Vector instructions from
// the scalar core are buffered with their rs1/rs2 operands in a small FIFO
// and issued in order to the vector unit. vsetvl/vsetvli/vsetivli (CONF)
// are serialised: all older instructions must complete first. The CONF must
// then complete before anything younger issues. Its new vl is written back
// to the scalar rd.
// Optional macro VEC_DISPATCH_PERF_EN adds issue and stall perf counters.

module vector_inst_dispatcher #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sc_inst_valid,
  input  logic [XLEN-1:0] sc_inst,
  input  logic [XLEN-1:0] sc_rs1_data,
  input  logic [XLEN-1:0] sc_rs2_data,
  output logic            sc_inst_ready,
  output logic            vec_inst_valid,
  output logic [XLEN-1:0] vec_inst,
  output logic [XLEN-1:0] vec_rs1_data,
  output logic [XLEN-1:0] vec_rs2_data,
  input  logic            vec_inst_ready,
  input  logic            vec_done,
  input  logic [XLEN-1:0] vec_vl,
  output logic            sc_rd_wr_en,
  output logic [4:0]      sc_rd_addr,
  output logic [XLEN-1:0] sc_rd_data,
`ifdef VEC_DISPATCH_PERF_EN
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall,
`endif
  output logic            dispatch_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    CFG_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [XLEN-1:0]  inst_mem [DEPTH];
  logic [XLEN-1:0]  rs1_mem  [DEPTH];
  logic [XLEN-1:0]  rs2_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] outstanding;
  logic [4:0]       conf_rd;

  logic             full;
  logic             empty;
  logic             opcode_ok;
  logic             accept;
  logic             push;
  logic             issue;
  logic             head_conf;
  logic [XLEN-1:0]  head_inst;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign opcode_ok = (sc_inst[6:0] == 7'h57) || (sc_inst[6:0] == 7'h07) ||
                     (sc_inst[6:0] == 7'h27);

  // The ready term is gated by reset so every output reads 0 while reset is held.
  assign sc_inst_ready = reset && !full;
  assign accept        = sc_inst_valid && sc_inst_ready;
  assign push          = accept && opcode_ok;
  assign issue         = vec_inst_valid && vec_inst_ready;

  assign head_inst = inst_mem[rd_ptr];
  assign head_conf = !empty && (head_inst[6:0] == 7'h57) && (head_inst[14:12] == 3'b111);

  // Issue qualification: in-order head, CONF waits for an idle vector unit.
  always_comb begin
    vec_inst_valid = 1'b0;
    case (state)
      RUN:      vec_inst_valid = !empty && !head_conf && (outstanding < OUT_W'(MAX_OUT));
      DRAIN:    vec_inst_valid = !empty && (outstanding == '0);
      default:  vec_inst_valid = 1'b0;
    endcase
  end

  assign vec_inst     = vec_inst_valid ? head_inst       : '0;
  assign vec_rs1_data = vec_inst_valid ? rs1_mem[rd_ptr] : '0;
  assign vec_rs2_data = vec_inst_valid ? rs2_mem[rd_ptr] : '0;

  // FIFO storage; data needs no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= sc_inst;
      rs1_mem[wr_ptr]  <= sc_rs1_data;
      rs2_mem[wr_ptr]  <= sc_rs2_data;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Issued-but-not-completed tracking; a completion with nothing in flight is an error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      outstanding  <= '0;
      dispatch_err <= 1'b0;
    end else begin
      if (issue && !vec_done) begin
        outstanding <= outstanding + OUT_W'(1);
      end else if (!issue && vec_done) begin
        if (outstanding == '0) dispatch_err <= 1'b1;
        else outstanding <= outstanding - OUT_W'(1);
      end
    end
  end

  // CONF serialisation FSM with the registered rd writeback.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      conf_rd     <= '0;
      sc_rd_wr_en <= 1'b0;
      sc_rd_addr  <= '0;
      sc_rd_data  <= '0;
    end else begin
      sc_rd_wr_en <= 1'b0;
      case (state)
        RUN: begin
          if (head_conf) state <= DRAIN;
        end
        DRAIN: begin
          if (issue) begin
            conf_rd <= head_inst[11:7];
            state   <= CFG_WAIT;
          end
        end
        CFG_WAIT: begin
          if (vec_done) begin
            sc_rd_wr_en <= (conf_rd != 5'd0);
            sc_rd_addr  <= conf_rd;
            sc_rd_data  <= vec_vl;
            state       <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef VEC_DISPATCH_PERF_EN
  // Free-running wrap-around counters for issues and stalled-with-work cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (issue) perf_issued <= perf_issued + 32'd1;
      if (!empty && !vec_inst_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_vector_inst_dispatcher.sv
// tb_vector_inst_dispatcher
// Directed, table-driven bench for vector_inst_dispatcher. Each table row is
// one clock cycle: inputs driven just after the rising edge, outputs compared
// on the falling edge of the same cycle. Reset sequences are hand-written.

module tb_vector_inst_dispatcher;

  localparam logic        H  = 1'b1;
  localparam logic        L  = 1'b0;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [4:0]  AZ = 5'd0;

  localparam logic [31:0] VLE  = 32'h02056007;
  localparam logic [31:0] VADD = 32'h022180D7;
  localparam logic [31:0] VSET = 32'h0D0572D7;
  localparam logic [31:0] ADD  = 32'h003100B3;

  typedef struct {
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_rs1;
    logic        vready;
    logic        done;
    logic [31:0] vl;
    logic        exp_ready;
    logic        exp_vvalid;
    logic [31:0] exp_inst;
    logic [31:0] exp_rs1;
    logic        exp_wr;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        sc_inst_valid;
  logic [31:0] sc_inst;
  logic [31:0] sc_rs1_data;
  logic [31:0] sc_rs2_data;
  logic        sc_inst_ready;
  logic        vec_inst_valid;
  logic [31:0] vec_inst;
  logic [31:0] vec_rs1_data;
  logic [31:0] vec_rs2_data;
  logic        vec_inst_ready;
  logic        vec_done;
  logic [31:0] vec_vl;
  logic        sc_rd_wr_en;
  logic [4:0]  sc_rd_addr;
  logic [31:0] sc_rd_data;
  logic        dispatch_err;
`ifdef VEC_DISPATCH_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  int tests_run;
  int tests_failed;
  vec_t tbl[$];

  vector_inst_dispatcher #(.XLEN(32), .DEPTH(4), .MAX_OUT(4)) dut (
    .clk(clk),
    .reset(reset),
    .sc_inst_valid(sc_inst_valid),
    .sc_inst(sc_inst),
    .sc_rs1_data(sc_rs1_data),
    .sc_rs2_data(sc_rs2_data),
    .sc_inst_ready(sc_inst_ready),
    .vec_inst_valid(vec_inst_valid),
    .vec_inst(vec_inst),
    .vec_rs1_data(vec_rs1_data),
    .vec_rs2_data(vec_rs2_data),
    .vec_inst_ready(vec_inst_ready),
    .vec_done(vec_done),
    .vec_vl(vec_vl),
    .sc_rd_wr_en(sc_rd_wr_en),
    .sc_rd_addr(sc_rd_addr),
    .sc_rd_data(sc_rd_data),
`ifdef VEC_DISPATCH_PERF_EN
    .perf_issued(perf_issued),
    .perf_stall(perf_stall),
`endif
    .dispatch_err(dispatch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic v, input logic [31:0] inst, input logic [31:0] rs1,
    input logic vr, input logic dn, input logic [31:0] vl,
    input logic er, input logic ev, input logic [31:0] ei, input logic [31:0] ers,
    input logic ew, input logic [4:0] ea, input logic [31:0] ed, input logic ee);
    vec_t r;
    r.in_valid = v;   r.in_inst = inst; r.in_rs1 = rs1;
    r.vready = vr;    r.done = dn;      r.vl = vl;
    r.exp_ready = er; r.exp_vvalid = ev; r.exp_inst = ei; r.exp_rs1 = ers;
    r.exp_wr = ew;    r.exp_addr = ea;  r.exp_data = ed; r.exp_err = ee;
    return r;
  endfunction

  // Drive one cycle of inputs just after the rising edge, then wait for the falling edge.
  task automatic applyStimulus(input vec_t v, input logic rst_n);
    @(posedge clk);
    #1;
    reset          = rst_n;
    sc_inst_valid  = v.in_valid;
    sc_inst        = v.in_inst;
    sc_rs1_data    = v.in_rs1;
    sc_rs2_data    = ~v.in_rs1;
    vec_inst_ready = v.vready;
    vec_done       = v.done;
    vec_vl         = v.vl;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s row %0d: got %h, expected %h", name, row, actual, expected);
    end
  endtask

  task automatic check_row(input int row, input vec_t v);
    checkOutput("sc_inst_ready", row, 32'(sc_inst_ready), 32'(v.exp_ready));
    checkOutput("vec_inst_valid", row, 32'(vec_inst_valid), 32'(v.exp_vvalid));
    checkOutput("sc_rd_wr_en", row, 32'(sc_rd_wr_en), 32'(v.exp_wr));
    checkOutput("dispatch_err", row, 32'(dispatch_err), 32'(v.exp_err));
    if (v.exp_vvalid) begin
      checkOutput("vec_inst", row, vec_inst, v.exp_inst);
      checkOutput("vec_rs1_data", row, vec_rs1_data, v.exp_rs1);
      checkOutput("vec_rs2_data", row, vec_rs2_data, ~v.exp_rs1);
    end
    if (v.exp_wr) begin
      checkOutput("sc_rd_addr", row, 32'(sc_rd_addr), 32'(v.exp_addr));
      checkOutput("sc_rd_data", row, sc_rd_data, v.exp_data);
    end
  endtask

  initial begin
    vec_t idle;
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b0;
    sc_inst_valid  = 1'b0;
    sc_inst        = '0;
    sc_rs1_data    = '0;
    sc_rs2_data    = '0;
    vec_inst_ready = 1'b0;
    vec_done       = 1'b0;
    vec_vl         = '0;

    // A: five vle32 with ready high; the fifth waits for MAX_OUT, then issue+done together.
    tbl.push_back(mk(H, VLE, 32'h100, H, L, Z,     H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h101, H, L, Z,     H, H, VLE, 32'h100,   L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h102, H, L, Z,     H, H, VLE, 32'h101,   L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h103, H, L, Z,     H, H, VLE, 32'h102,   L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h104, H, L, Z,     H, H, VLE, 32'h103,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, H, 32'h4,         H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, H, 32'h4,         H, H, VLE, 32'h104,   L, AZ, Z, L));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(L, Z, Z, H, H, 32'h4,       H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, L, Z, Z,           L, AZ, Z, L));

    // B: ready low, fill to full, fifth offer refused, head held, then drain.
    tbl.push_back(mk(H, VLE, 32'h200, L, L, Z,     H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h201, L, L, Z,     H, H, VLE, 32'h200,   L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h202, L, L, Z,     H, H, VLE, 32'h200,   L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h203, L, L, Z,     H, H, VLE, 32'h200,   L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h2FF, L, L, Z,     L, H, VLE, 32'h200,   L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h2FF, L, L, Z,     L, H, VLE, 32'h200,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             L, H, VLE, 32'h200,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, H, VLE, 32'h201,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, H, VLE, 32'h202,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, H, VLE, 32'h203,   L, AZ, Z, L));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(L, Z, Z, H, H, 32'h4,       H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, L, Z, Z,           L, AZ, Z, L));

    // C: vadd, vadd, vsetvli x5; CONF waits for drain, rd writeback of vl = 8.
    tbl.push_back(mk(H, VADD, 32'h300, H, L, Z,    H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(H, VADD, 32'h301, H, L, Z,    H, H, VADD, 32'h300,  L, AZ, Z, L));
    tbl.push_back(mk(H, VSET, 32'h10, H, L, Z,     H, H, VADD, 32'h301,  L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, H, 32'h77,        H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, H, 32'h77,        H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, H, VSET, 32'h10,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, H, 32'h8,         H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, L, Z, Z,           H, 5'd5, 32'h8, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, L, Z, Z,           L, AZ, Z, L));

    // D: scalar opcode 0x33 is consumed but never enqueued; FIFO still holds four more.
    tbl.push_back(mk(H, ADD, 32'h400, L, L, Z,     H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h401, L, L, Z,     H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h402, L, L, Z,     H, H, VLE, 32'h401,   L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h403, L, L, Z,     H, H, VLE, 32'h401,   L, AZ, Z, L));
    tbl.push_back(mk(H, VLE, 32'h404, L, L, Z,     H, H, VLE, 32'h401,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, L, L, Z,             L, H, VLE, 32'h401,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             L, H, VLE, 32'h401,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, H, VLE, 32'h402,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, H, VLE, 32'h403,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, H, VLE, 32'h404,   L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, L, Z, Z,           L, AZ, Z, L));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(L, Z, Z, H, H, 32'h4,       H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, L, Z, Z,           L, AZ, Z, L));

    // E: completion with nothing outstanding sets the sticky error.
    tbl.push_back(mk(L, Z, Z, H, H, 32'h4,         H, L, Z, Z,           L, AZ, Z, L));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, L, Z, Z,           L, AZ, Z, H));
    tbl.push_back(mk(L, Z, Z, H, L, Z,             H, L, Z, Z,           L, AZ, Z, H));

    idle = mk(L, Z, Z, L, L, Z, L, L, Z, Z, L, AZ, Z, L);

    // Reset held: every output low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_row(-1, idle);

    // First cycle after release: ready high, nothing presented.
    applyStimulus(idle, 1'b1);
    check_row(0, mk(L, Z, Z, L, L, Z, H, L, Z, Z, L, AZ, Z, L));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], 1'b1);
      check_row(i + 1, tbl[i]);
    end

    // F: reset while CFG_WAIT with two entries queued behind the CONF.
    applyStimulus(mk(H, VSET, 32'h20, H, L, Z, L, L, Z, Z, L, AZ, Z, L), 1'b1);
    check_row(101, mk(L, Z, Z, L, L, Z, H, L, Z, Z, L, AZ, Z, H));
    applyStimulus(mk(H, VADD, 32'h500, H, L, Z, L, L, Z, Z, L, AZ, Z, L), 1'b1);
    check_row(102, mk(L, Z, Z, L, L, Z, H, L, Z, Z, L, AZ, Z, H));
    applyStimulus(mk(H, VADD, 32'h501, H, L, Z, L, L, Z, Z, L, AZ, Z, L), 1'b1);
    check_row(103, mk(L, Z, Z, L, L, Z, H, H, VSET, 32'h20, L, AZ, Z, H));
    applyStimulus(mk(L, Z, Z, H, H, 32'h9, L, L, Z, Z, L, AZ, Z, L), 1'b0);
    check_row(104, mk(L, Z, Z, L, L, Z, L, L, Z, Z, L, AZ, Z, H));
    applyStimulus(mk(L, Z, Z, H, L, Z, L, L, Z, Z, L, AZ, Z, L), 1'b1);
    check_row(105, mk(L, Z, Z, L, L, Z, H, L, Z, Z, L, AZ, Z, L));
    applyStimulus(mk(H, VADD, 32'h600, H, L, Z, L, L, Z, Z, L, AZ, Z, L), 1'b1);
    check_row(106, mk(L, Z, Z, L, L, Z, H, L, Z, Z, L, AZ, Z, L));
    applyStimulus(mk(L, Z, Z, H, L, Z, L, L, Z, Z, L, AZ, Z, L), 1'b1);
    check_row(107, mk(L, Z, Z, L, L, Z, H, H, VADD, 32'h600, L, AZ, Z, L));
    applyStimulus(mk(L, Z, Z, H, H, 32'h4, L, L, Z, Z, L, AZ, Z, L), 1'b1);
    check_row(108, mk(L, Z, Z, L, L, Z, H, L, Z, Z, L, AZ, Z, L));
    applyStimulus(mk(L, Z, Z, H, L, Z, L, L, Z, Z, L, AZ, Z, L), 1'b1);
    check_row(109, mk(L, Z, Z, L, L, Z, H, L, Z, Z, L, AZ, Z, L));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
